// File: rtl/cute_key_sequencer.sv
// Key sequencer: stores NUM_KEYS secret keys and, once committed, presents the key
// for the current time window on key_out, stepping in lockstep with the locked FSM's counter.
module cute_key_sequencer #(
   parameter  int KEY_W    = 12,
   parameter  int NUM_KEYS = 4,
   parameter  int WIN_LEN  = 12,
   localparam int PERIOD   = NUM_KEYS * WIN_LEN,
   localparam int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
   localparam int CNT_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [KEY_W-1:0] load_data,
   output logic             load_ready,
   input  logic             commit,
   output logic             armed,
   output logic [KEY_W-1:0] key_out,
   output logic [IDX_W-1:0] win_idx,
   output logic             load_err
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_FULL  = 2'd1,
      ST_ARMED = 2'd2
   } state_e;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [NUM_KEYS-1:0] mask_q, mask_d;
   logic [KEY_W-1:0]    key_q [NUM_KEYS];
   logic                armed_q;
   logic                load_err_q;
   logic                err_d;
   logic                load_ok_s;
   logic                idx_ok_s;

   assign idx_ok_s = ({{(32-IDX_W){1'b0}}, load_idx} < 32'(NUM_KEYS));

   // Free-running window counter plus load/commit legality decode
   always_comb begin
      cnt_d     = (cnt_q == CNT_W'(PERIOD - 1)) ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      mask_d    = mask_q;
      load_ok_s = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         ST_LOAD: begin
            if (load_valid) begin
               if (idx_ok_s && !mask_q[load_idx]) begin
                  load_ok_s        = 1'b1;
                  mask_d[load_idx] = 1'b1;
                  err_d            = commit;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               err_d = commit;
            end
         end
         ST_FULL: begin
            err_d = 1'b0;
         end
         ST_ARMED: begin
            err_d = load_valid | commit;
         end
         default: begin
            err_d = 1'b0;
         end
      endcase
   end

   // All state moves on the falling edge so the locked FSM sees a stable key on its own edge
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_LOAD;
         cnt_q      <= {CNT_W{1'b0}};
         mask_q     <= {NUM_KEYS{1'b0}};
         armed_q    <= 1'b0;
         load_err_q <= 1'b0;
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_q[i] <= {KEY_W{1'b0}};
         end
      end else begin
         cnt_q      <= cnt_d;
         mask_q     <= mask_d;
         load_err_q <= err_d;
         if (load_ok_s) begin
            key_q[load_idx] <= load_data;
         end
         case (state_q)
            ST_LOAD: begin
               if (&mask_d) begin
                  state_q <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (commit) begin
                  state_q <= ST_ARMED;
                  armed_q <= 1'b1;
               end
            end
            ST_ARMED: begin
               state_q <= ST_ARMED;
            end
            default: begin
               state_q <= ST_LOAD;
               armed_q <= 1'b0;
            end
         endcase
      end
   end

   // Bit KEY_W-1 of the key drives keyinput0 of the locked FSM
   assign win_idx    = IDX_W'({{(32-CNT_W){1'b0}}, cnt_q} / 32'(WIN_LEN));
   assign key_out    = armed_q ? key_q[win_idx] : {KEY_W{1'b0}};
   assign load_ready = (state_q == ST_LOAD);
   assign armed      = armed_q;
   assign load_err   = load_err_q;

endmodule

// File: doc/cute_key_sequencer.md
Name: cute_key_sequencer

Overview:
- Key-provisioning counterpart to the time-windowed, key-locked behavioural FSMs: generates the time-varying key those FSMs check.
- Holds NUM_KEYS secret keys loaded through a valid/ready port.
- After commit, drives the key for the current window on key_out, using a window counter that tracks the locked FSM's counter edge for edge.
- Sits beside the locked FSM on the same clk/rst; key_out wires straight to its keyinput bus.

Parameters:
- KEY_W, 12, width of each key and of key_out.
- NUM_KEYS, 4, number of key windows per period.
- WIN_LEN, 12, clock cycles per window; period P = NUM_KEYS*WIN_LEN (default 48).

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the locked FSM.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  key-load request.
- load_idx  input  clog2(NUM_KEYS)  slot being written.
- load_data  input  KEY_W  key value. Bit KEY_W-1 maps to keyinput0; bit 0 maps to keyinput(KEY_W-1).
- load_ready  output  1  sequencer accepts keys.
- commit  input  1  arm request.
- armed  output  1  keys committed; key_out live.
- key_out  output  KEY_W  key for the current window; all zeros when not armed.
- win_idx  output  clog2(NUM_KEYS)  current window number, cnt / WIN_LEN.
- load_err  output  1  one-cycle pulse on an illegal load or commit.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - cnt=0, all key registers=0, loaded mask=0, state=LOAD.
  - armed=0, load_err=0, key_out=0, win_idx=0.
  - load_ready reads 1 (it is decoded from state=LOAD); no transfer can occur while rst=0.
- Counter:
  - cnt is clog2(P) bits.
  - It increments on every falling edge once rst=1, in every state. After the edge where cnt=P-1 it holds 0.
  - It is never gated, stalled or resynchronised, so it stays equal to the locked FSM's counter.
- win_idx is decoded combinationally from cnt: cnt 0..WIN_LEN-1 gives 0, and so on up to NUM_KEYS-1.
- key_out is combinational: key_reg[win_idx] when armed=1, else 0. It is stable between falling edges, so the locked FSM samples the key that matches the counter value it sees on the same edge.
- State machine (all transitions on the falling edge):
  - LOAD: load_ready=1. A transfer happens when load_valid=1, and it writes key_reg[load_idx] and sets mask[load_idx].
    - If the slot's mask bit is already set: no write, load_err pulses.
    - If load_idx >= NUM_KEYS: no write, load_err pulses.
    - When the mask becomes all ones, go to FULL.
  - FULL: load_ready=0; load_valid is ignored with no error. commit=1 goes to ARMED, and armed rises after that edge.
  - ARMED: absorbing; only reset leaves it. load_valid=1 or commit=1 pulses load_err, with no state change.
- Illegal commit: commit=1 in LOAD is ignored and pulses load_err. This includes the edge whose load completes the mask, because commit is judged against the state before the edge.
- Erroneous load plus commit in the same cycle: a single load_err pulse.
- load_err is registered, high for exactly one cycle after the offending edge.
- Reset mid-load or while armed clears all keys and the mask. key_out drops to 0 asynchronously, and the locked FSM then sees a wrong key until re-armed.
- Keys are never readable except through key_out while armed.

Test Plan:
- Reset, then 5 falling edges with no loads -> cnt=5, win_idx=0, key_out=0x000, load_ready=1, armed=0.
- Load slots 0..3 with 0x8A5, 0x03A, 0xD7B, 0x9B4, one per cycle -> load_ready=0 after the 4th edge. Commit -> armed=1; key_out equals 0x8A5 for cnt 0-11, 0x03A for 12-23, 0xD7B for 24-35 and 0x9B4 for 36-47, then wraps to 0x8A5 at cnt=0.
- Write slot 1 twice while in LOAD -> second write ignored, load_err high one cycle, key_reg[1] holds the first value.
- Commit with 3 of 4 slots loaded -> load_err pulse, armed stays 0. Complete the load and commit again -> armed=1.
- Armed, then load_valid=1 with idx 0 and data 0xFFF -> load_err pulse, key_out unchanged at 0x8A5 in window 0.
- Assert rst low mid-window 2 while armed -> key_out=0 and cnt=0 immediately. After release, cnt restarts at 0 in lockstep with the locked FSM; with 4 reloads and a commit, the locked FSM's outputs match the unlocked reference.
